// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry-in, carry-out, signed overflow and zero flags.
// The carry chain uses 4-bit carry-lookahead groups that ripple from group to group.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] gen, prop;
  logic [WIDTH-1:0] sum_next;
  logic             c_next;
  logic             c_in_msb;
  logic             carry;
  logic [3:0]       gb, pb;
  logic             c1, c2, c3;
  logic             grp_g, grp_p;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each group resolves its internal carries from its own carry-in; only the
  // group carry-out (G | P & cin) travels on to the next group.
  always_comb begin
    carry    = ci;
    sum_next = '0;
    c_in_msb = 1'b0;
    gb       = '0;
    pb       = '0;
    c1       = 1'b0;
    c2       = 1'b0;
    c3       = 1'b0;
    grp_g    = 1'b0;
    grp_p    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gb = gen[4*k +: 4];
      pb = prop[4*k +: 4];
      c1 = gb[0] | (pb[0] & carry);
      c2 = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & carry);
      c3 = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
         | (pb[2] & pb[1] & pb[0] & carry);
      grp_g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
            | (pb[3] & pb[2] & pb[1] & gb[0]);
      grp_p = &pb;
      sum_next[4*k +: 4] = pb ^ {c3, c2, c1, carry};
      c_in_msb = c3;
      carry    = grp_g | (grp_p & carry);
    end
    c_next = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      c         <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_next;
        c    <= c_next;
        ovf  <= c_next ^ c_in_msb;
        zero <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases plus randomized traffic
// compared against a plain-arithmetic reference model.
module tb_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a, b;
  logic             ci, in_valid;
  logic [WIDTH-1:0] sum;
  logic             c, ovf, zero, out_valid;
  logic [WIDTH+3:0] obs;

  int checks = 0;
  int fails  = 0;

  adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .in_valid(in_valid),
    .sum(sum), .c(c), .ovf(ovf), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  assign obs = {sum, c, ovf, zero, out_valid};

  // Expected {sum, c, ovf, zero, out_valid} for one accepted operand set.
  function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic cin);
    logic [WIDTH:0] total;
    int sx, sy, ss;
    logic v;
    total = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    sx = int'($signed(x));
    sy = int'($signed(y));
    ss = sx + sy + (cin ? 1 : 0);
    v  = (ss > (2 ** (WIDTH - 1)) - 1) || (ss < -(2 ** (WIDTH - 1)));
    return {total[WIDTH-1:0], total[WIDTH], v, (total[WIDTH-1:0] == '0), 1'b1};
  endfunction

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic cin, input logic v);
    @(negedge clk);
    a = x; b = y; ci = cin; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH+3:0] exp;
    rst = 1'b1; a = '0; b = '0; ci = 1'b0; in_valid = 1'b0;
    #1;
    exp = {{WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL reset_immediate got %h want %h", obs, exp);
    end
    drive(8'h05, 8'h07, 1'b1, 1'b1);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL reset_ignores_edge got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nibble_sweep();
    logic [WIDTH+3:0] exp;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(WIDTH'(i), WIDTH'(j), 1'b0, 1'b1);
        exp = model(WIDTH'(i), WIDTH'(j), 1'b0);
        checks++;
        if (obs !== exp) begin
          fails++;
          $display("[TB] FAIL sweep %0d+%0d got %h want %h", i, j, obs, exp);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] xs [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h0F, 8'hFF};
    logic [WIDTH-1:0] ys [8] = '{8'h00, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h80, 8'h01, 8'h00};
    logic             cs [8] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [WIDTH+3:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive(xs[i], ys[i], cs[i], 1'b1);
      exp = model(xs[i], ys[i], cs[i]);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL directed %h+%h+%b got %h want %h", xs[i], ys[i], cs[i], obs, exp);
      end
    end
    // Independent literal checks of the headline corner results.
    drive(8'h7F, 8'h01, 1'b0, 1'b1);
    checks++;
    if ({sum, c, ovf} !== {8'h80, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL ovf_pos got %h want %h", {sum, c, ovf}, {8'h80, 1'b0, 1'b1});
    end
    drive(8'hFF, 8'h01, 1'b0, 1'b1);
    checks++;
    if ({sum, c, ovf, zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL wrap_zero got %h want %h", {sum, c, ovf, zero}, {8'h00, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_hold();
    logic [WIDTH+3:0] exp;
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    exp = {8'h46, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL hold_load got %h want %h", obs, exp);
    end
    exp[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL hold_cycle%0d got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_no_comb_path();
    logic [WIDTH+3:0] exp;
    drive(8'h21, 8'h43, 1'b1, 1'b1);
    exp = model(8'h21, 8'h43, 1'b1);
    a = 8'hFF; b = 8'hFF; ci = 1'b1; in_valid = 1'b0;
    #2;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL no_comb_path got %h want %h", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH+3:0] exp;
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp = {{WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL async_reset got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 8'h10; b = 8'h20; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp = {8'h30, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL after_reset got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH+3:0] exp;
    logic [WIDTH-1:0] x, y;
    logic cin, v;
    exp = obs;
    exp[0] = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      x = WIDTH'($urandom); y = WIDTH'($urandom);
      cin = 1'($urandom); v = ($urandom_range(0, 3) != 0);
      drive(x, y, cin, v);
      if (v) exp = model(x, y, cin);
      else   exp[0] = 1'b0;
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL random%0d %h+%h+%b v=%b got %h want %h", i, x, y, cin, v, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nibble_sweep();
    test_directed();
    test_hold();
    test_no_comb_path();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
